// File: rtl/regfile_arbiter.sv
// Two-requester round-robin front end for the single-port 8x16 register file.
// Serialises accesses, drives the RF port for one cycle, returns read data and ACK pulses.
module regfile_arbiter #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       REQ0,
    input  logic                       REQ1,
    input  logic                       WE0,
    input  logic                       WE1,
    input  logic [$clog2(DEPTH)-1:0]   ADDR0,
    input  logic [$clog2(DEPTH)-1:0]   ADDR1,
    input  logic [WIDTH-1:0]           WDATA0,
    input  logic [WIDTH-1:0]           WDATA1,
    output logic                       GNT0,
    output logic                       GNT1,
    output logic                       ACK0,
    output logic                       ACK1,
    output logic [WIDTH-1:0]           RDATA0,
    output logic [WIDTH-1:0]           RDATA1,
    output logic                       BUSY,
    output logic                       RF_WrEn,
    output logic                       RF_RdEn,
    output logic [$clog2(DEPTH)-1:0]   RF_Address,
    output logic [WIDTH-1:0]           RF_WrData,
    input  logic [WIDTH-1:0]           RF_RdData
);

    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic [WIDTH-1:0]    rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                busy_q, busy_d;
    logic                rf_wren_q, rf_wren_d, rf_rden_q, rf_rden_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [WIDTH-1:0]    rf_wdata_q, rf_wdata_d;
    logic                sel;

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        we_d       = we_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rf_wren_d  = 1'b0;
        rf_rden_d  = 1'b0;
        rf_addr_d  = '0;
        rf_wdata_d = '0;
        sel        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    // Contention goes to the pointer; the winner then drops to lowest priority.
                    sel        = (REQ0 && REQ1) ? ptr_q : REQ1;
                    win_d      = sel;
                    ptr_d      = ~sel;
                    we_d       = sel ? WE1 : WE0;
                    rf_addr_d  = sel ? ADDR1 : ADDR0;
                    rf_wdata_d = sel ? WDATA1 : WDATA0;
                    rf_wren_d  = we_d;
                    rf_rden_d  = ~we_d;
                    gnt0_d     = ~sel;
                    gnt1_d     = sel;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    ack0_d  = ~win_q;
                    ack1_d  = win_q;
                    state_d = IDLE;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (win_q) rdata1_d = RF_RdData;
                else       rdata0_d = RF_RdData;
                ack0_d  = ~win_q;
                ack1_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
            rf_wren_q  <= 1'b0;
            rf_rden_q  <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            we_q       <= we_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
            rf_wren_q  <= rf_wren_d;
            rf_rden_q  <= rf_rden_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign GNT0       = gnt0_q;
    assign GNT1       = gnt1_q;
    assign ACK0       = ack0_q;
    assign ACK1       = ack1_q;
    assign RDATA0     = rdata0_q;
    assign RDATA1     = rdata1_q;
    assign BUSY       = busy_q;
    assign RF_WrEn    = rf_wren_q;
    assign RF_RdEn    = rf_rden_q;
    assign RF_Address = rf_addr_q;
    assign RF_WrData  = rf_wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: a transaction-level model predicts grant order,
// register contents and read results; a monitor checks every GNT/ACK against it.
module tb_regfile_arbiter;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             REQ0, REQ1, WE0, WE1;
    logic [AW-1:0]    ADDR0, ADDR1;
    logic [WIDTH-1:0] WDATA0, WDATA1;
    logic             GNT0, GNT1, ACK0, ACK1, BUSY;
    logic [WIDTH-1:0] RDATA0, RDATA1;
    logic             RF_WrEn, RF_RdEn;
    logic [AW-1:0]    RF_Address;
    logic [WIDTH-1:0] RF_WrData;
    logic [WIDTH-1:0] RF_RdData;

    regfile_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
        .RDATA0(RDATA0), .RDATA1(RDATA1), .BUSY(BUSY),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_WrData(RF_WrData), .RF_RdData(RF_RdData)
    );

    always #5 CLK = ~CLK;

    // Behavioural register file: synchronous write, registered read.
    logic [WIDTH-1:0] rf_mem [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] rf_rd = '0;
    always @(posedge CLK) begin
        if (RF_WrEn) rf_mem[RF_Address] <= RF_WrData;
        if (RF_RdEn) rf_rd <= rf_mem[RF_Address];
    end
    assign RF_RdData = rf_rd;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        bit               req;
        bit               we;
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] wdata;
        logic [WIDTH-1:0] rd0;
        logic [WIDTH-1:0] rd1;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] ref_mem [DEPTH] = '{default: '0};
    logic [WIDTH-1:0] ref_rd [2] = '{default: '0};
    bit               ref_ptr = 1'b0;

    bit               f_we    [2][2];
    logic [AW-1:0]    f_addr  [2][2];
    logic [WIDTH-1:0] f_wdata [2][2];

    task automatic rand_fields();
        for (int x = 0; x < 2; x++)
            for (int k = 0; k < 2; k++) begin
                f_we[x][k]    = 1'($urandom);
                f_addr[x][k]  = AW'($urandom);
                f_wdata[x][k] = WIDTH'($urandom);
            end
    endtask

    // Predict service order: each requester keeps asking until it has had rem[x] grants.
    task automatic plan_round(int rem0, int rem1);
        int   rem [2];
        int   k [2];
        int   w;
        exp_t it;
        rem[0] = rem0; rem[1] = rem1; k[0] = 0; k[1] = 0;
        while (rem[0] + rem[1] > 0) begin
            if (rem[0] > 0 && rem[1] > 0) w = ref_ptr ? 1 : 0;
            else                          w = (rem[1] > 0) ? 1 : 0;
            ref_ptr  = (w == 0);
            it.req   = (w == 1);
            it.we    = f_we[w][k[w]];
            it.addr  = f_addr[w][k[w]];
            it.wdata = f_wdata[w][k[w]];
            if (it.we) ref_mem[it.addr] = it.wdata;
            else       ref_rd[w] = ref_mem[it.addr];
            it.rd0 = ref_rd[0];
            it.rd1 = ref_rd[1];
            exp_q.push_back(it);
            k[w]++;
            rem[w]--;
        end
    endtask

    task automatic drive0(bit on, int k);
        REQ0 = on;
        if (on) begin WE0 = f_we[0][k]; ADDR0 = f_addr[0][k]; WDATA0 = f_wdata[0][k]; end
        else begin WE0 = 1'($urandom); ADDR0 = AW'($urandom); WDATA0 = WIDTH'($urandom); end
    endtask

    task automatic drive1(bit on, int k);
        REQ1 = on;
        if (on) begin WE1 = f_we[1][k]; ADDR1 = f_addr[1][k]; WDATA1 = f_wdata[1][k]; end
        else begin WE1 = 1'($urandom); ADDR1 = AW'($urandom); WDATA1 = WIDTH'($urandom); end
    endtask

    task automatic do_round(int rem0, int rem1);
        int idx0 = 0, idx1 = 0, acks = 0;
        plan_round(rem0, rem1);
        @(posedge CLK); #1;
        drive0(rem0 > 0, 0);
        drive1(rem1 > 0, 0);
        for (int cyc = 0; cyc < 40 && acks < rem0 + rem1; cyc++) begin
            @(posedge CLK); #1;
            if (GNT0) begin idx0++; drive0(idx0 < rem0, (idx0 < rem0) ? idx0 : 0); end
            if (GNT1) begin idx1++; drive1(idx1 < rem1, (idx1 < rem1) ? idx1 : 0); end
            if (ACK0) acks++;
            if (ACK1) acks++;
        end
        check("round_acks", acks, rem0 + rem1);
    endtask

    task automatic check_zero(string name);
        check(name, {GNT0, GNT1, ACK0, ACK1, BUSY, RF_WrEn, RF_RdEn, RF_Address,
                     RF_WrData, RDATA0, RDATA1}, 64'd0);
    endtask

    bit mon_en = 1'b0;

    task automatic reset_pulse(bit mid_write);
        mon_en = 1'b0;
        @(posedge CLK); #1;
        if (mid_write) begin
            REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = AW'($urandom); WDATA0 = 16'hbeef; REQ1 = 1'b0;
            @(posedge CLK); #1;
            check("rst_pre_wren", {GNT0, RF_WrEn}, 2'b11);
            REQ0 = 1'b0;
        end
        #2 RST = 1'b1;
        #1 check_zero(mid_write ? "reset_mid_write" : "reset_async");
        exp_q.delete();
        ref_ptr = 1'b0;
        ref_rd  = '{default: '0};
        @(posedge CLK); #1;
        check_zero("reset_held");
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("post_reset_quiet", {GNT0, GNT1, ACK0, ACK1, BUSY}, 5'd0);
        end
        mon_en = 1'b1;
    endtask

    // Monitor: checks the RF port on grants and the data/latency on acks.
    int gnt_age = 0;
    always @(negedge CLK) begin
        exp_t it;
        if (mon_en) begin
            gnt_age++;
            check("rf_en_only_in_grant", {RF_WrEn | RF_RdEn, RF_WrEn & RF_RdEn},
                  {GNT0 | GNT1, 1'b0});
            if (GNT0 || GNT1) begin
                if (exp_q.size() == 0) check("unexpected_grant", exp_q.size(), 1);
                else begin
                    it = exp_q[0];
                    check("gnt_who", {GNT1, GNT0}, it.req ? 2'b10 : 2'b01);
                    check("gnt_enables", {RF_WrEn, RF_RdEn}, {it.we, !it.we});
                    check("gnt_addr", RF_Address, it.addr);
                    if (it.we) check("gnt_wdata", RF_WrData, it.wdata);
                    check("gnt_busy", BUSY, 1);
                end
                gnt_age = 0;
            end
            if (ACK0 || ACK1) begin
                if (exp_q.size() == 0) check("unexpected_ack", exp_q.size(), 1);
                else begin
                    it = exp_q.pop_front();
                    check("ack_who", {ACK1, ACK0}, it.req ? 2'b10 : 2'b01);
                    check("ack_latency", gnt_age, it.we ? 1 : 2);
                    check("rdata0", RDATA0, it.rd0);
                    check("rdata1", RDATA1, it.rd1);
                    check("ack_busy", BUSY, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1;
        RST = 1'b1;
        drive0(1'b0, 0);
        drive1(1'b0, 0);
        #3 check_zero("reset_initial");
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        mon_en = 1'b1;

        // Write 14 to reg 2 from requester 0, then read it back from requester 1.
        f_we[0][0] = 1'b1; f_addr[0][0] = 3'd2; f_wdata[0][0] = 16'd14;
        do_round(1, 0);
        f_we[1][0] = 1'b0; f_addr[1][0] = 3'd2; f_wdata[1][0] = 16'd0;
        do_round(0, 1);

        // Simultaneous requests after reset, then with the pointer rotated.
        reset_pulse(1'b0);
        f_we[0][0] = 1'b1; f_addr[0][0] = 3'd3; f_wdata[0][0] = 16'd6;
        f_we[1][0] = 1'b0; f_addr[1][0] = 3'd3; f_wdata[1][0] = 16'd0;
        do_round(1, 1);
        rand_fields();
        do_round(1, 0);
        rand_fields();
        do_round(1, 1);

        // Requester 0 holds REQ through several grants while 1 asks once.
        rand_fields();
        do_round(2, 1);

        for (int n = 0; n < 60; n++) begin
            rand_fields();
            r0 = $urandom_range(0, 2);
            r1 = $urandom_range(0, 2);
            if (r0 + r1 == 0) r0 = 1;
            do_round(r0, r1);
        end

        reset_pulse(1'b1);
        for (int n = 0; n < 10; n++) begin
            rand_fields();
            do_round($urandom_range(1, 2), $urandom_range(0, 2));
        end

        repeat (4) @(posedge CLK);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
